// File: rtl/esm_issue_scheduler_if.sv
// Handshake bundle between the IDA/instruction buffer, the issue scheduler and execute.
// The scheduler connects through the slave modport; the surrounding pipeline connects through master.
interface esm_issue_scheduler_if #(
    parameter int bs = 16,
    parameter int IW = $clog2(bs)
);
    logic          alloc_valid;
    logic [IW-1:0] alloc_index;
    logic [bs-1:0] alloc_deps;
    logic          alloc_ready;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          issue_ready;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic [IW:0]   occupancy;
    logic          full;

    modport master (
        output alloc_valid, alloc_index, alloc_deps, issue_ready,
               complete_valid, complete_index,
        input  alloc_ready, issue_valid, issue_index, occupancy, full
    );

    modport slave (
        input  alloc_valid, alloc_index, alloc_deps, issue_ready,
               complete_valid, complete_index,
        output alloc_ready, issue_valid, issue_index, occupancy, full
    );
endinterface

// File: rtl/esm_issue_scheduler.sv
// Dependency-matrix issue scheduler: stores one dependency row per buffer entry, offers the
// lowest-index entry with no live dependencies, and clears a column when its entry completes.
module esm_issue_scheduler #(
    parameter int bs = 16,
    parameter int IW = $clog2(bs)
) (
    input  logic                 clk,
    input  logic                 rst,
    esm_issue_scheduler_if.slave sched
);
    logic          valid_reg  [bs];
    logic          picked_reg [bs];
    logic [bs-1:0] dm_reg     [bs];

    logic [bs-1:0] valid_vec;
    logic [bs-1:0] picked_vec;
    logic [bs-1:0] ready_vec;

    logic          issue_valid_reg;
    logic [IW-1:0] issue_index_reg;
    logic [IW:0]   occupancy_reg;

    logic          alloc_fire;
    logic          complete_fire;
    logic          load_issue;
    logic          pick_fire;
    logic          sel_found;
    logic [IW-1:0] sel_index;
    logic [bs-1:0] alloc_mask;
    logic [bs-1:0] complete_mask;
    logic [bs-1:0] alloc_row;

    genvar gi;
    generate
        for (gi = 0; gi < bs; gi++) begin : g_vec
            assign valid_vec[gi]  = valid_reg[gi];
            assign picked_vec[gi] = picked_reg[gi];
            assign ready_vec[gi]  = valid_reg[gi] & ~picked_reg[gi] & ~|dm_reg[gi];
        end
    endgenerate

    // alloc_ready looks only at pre-edge valid, so a slot completing this cycle is not reusable yet.
    assign sched.alloc_ready = ~valid_vec[sched.alloc_index];
    assign alloc_fire        = sched.alloc_valid & ~valid_vec[sched.alloc_index];
    assign complete_fire     = sched.complete_valid & valid_vec[sched.complete_index]
                             & picked_vec[sched.complete_index];

    assign alloc_mask    = bs'(1) << sched.alloc_index;
    assign complete_mask = complete_fire ? (bs'(1) << sched.complete_index) : '0;
    assign alloc_row     = sched.alloc_deps & valid_vec & ~alloc_mask & ~complete_mask;

    assign load_issue = ~issue_valid_reg | sched.issue_ready;
    assign pick_fire  = load_issue & sel_found;

    // Fixed-priority encoder: scanning downward lets the lowest ready index win.
    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_index = IW'(i);
            end
        end
    end

    generate
        for (gi = 0; gi < bs; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi]  <= 1'b0;
                    picked_reg[gi] <= 1'b0;
                    dm_reg[gi]     <= '0;
                end else if (alloc_fire && (sched.alloc_index == IW'(gi))) begin
                    valid_reg[gi]  <= 1'b1;
                    picked_reg[gi] <= 1'b0;
                    dm_reg[gi]     <= alloc_row;
                end else begin
                    if (complete_fire && (sched.complete_index == IW'(gi))) begin
                        valid_reg[gi]  <= 1'b0;
                        picked_reg[gi] <= 1'b0;
                    end else if (pick_fire && (sel_index == IW'(gi))) begin
                        picked_reg[gi] <= 1'b1;
                    end
                    dm_reg[gi] <= dm_reg[gi] & ~complete_mask;
                end
            end
        end
    endgenerate

    // The offer register only reloads when empty or accepted, so a stalled offer never changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_reg <= 1'b0;
            issue_index_reg <= '0;
        end else if (load_issue) begin
            issue_valid_reg <= sel_found;
            if (sel_found) begin
                issue_index_reg <= sel_index;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_reg <= '0;
        end else begin
            case ({alloc_fire, complete_fire})
                2'b10:   occupancy_reg <= occupancy_reg + (IW+1)'(1);
                2'b01:   occupancy_reg <= occupancy_reg - (IW+1)'(1);
                default: occupancy_reg <= occupancy_reg;
            endcase
        end
    end

    assign sched.issue_valid = issue_valid_reg;
    assign sched.issue_index = issue_index_reg;
    assign sched.occupancy   = occupancy_reg;
    assign sched.full        = (occupancy_reg == (IW+1)'(bs));
endmodule
